// File: rtl/vram_port_arbiter_if.sv
// Requester-side and RAM-side signal bundle for the framebuffer port arbiter.
// The arbiter takes the slave view; requesters and the RAM model take the master view.
interface vram_port_arbiter_if #(
    parameter int ADDR_W  = 18,
    parameter int WDATA_W = 32,
    parameter int RDATA_W = 8
);
    logic               vga_rd_req;
    logic [ADDR_W-1:0]  vga_rd_addr;
    logic               vga_rd_valid;
    logic               vga_drop;
    logic [15:0]        vga_drop_count;

    logic               cpu_rd_req;
    logic [ADDR_W-1:0]  cpu_rd_addr;
    logic               cpu_rd_ack;
    logic               cpu_rd_valid;

    logic               cpu_wr_req;
    logic [ADDR_W-1:0]  cpu_wr_addr;
    logic [WDATA_W-1:0] cpu_wr_data;
    logic               cpu_wr_ack;

    logic               ldr_wr_req;
    logic [ADDR_W-1:0]  ldr_wr_addr;
    logic [WDATA_W-1:0] ldr_wr_data;
    logic               ldr_wr_ack;

    logic [RDATA_W-1:0] rd_data;
    logic [ADDR_W-1:0]  mem_rdaddress;
    logic [RDATA_W-1:0] mem_q;
    logic [ADDR_W-1:0]  mem_wraddress;
    logic [WDATA_W-1:0] mem_data;
    logic               mem_wren;

    modport slave (
        input  vga_rd_req, vga_rd_addr,
        output vga_rd_valid, vga_drop, vga_drop_count,
        input  cpu_rd_req, cpu_rd_addr,
        output cpu_rd_ack, cpu_rd_valid,
        input  cpu_wr_req, cpu_wr_addr, cpu_wr_data,
        output cpu_wr_ack,
        input  ldr_wr_req, ldr_wr_addr, ldr_wr_data,
        output ldr_wr_ack,
        output rd_data, mem_rdaddress,
        input  mem_q,
        output mem_wraddress, mem_data, mem_wren
    );

    modport master (
        output vga_rd_req, vga_rd_addr,
        input  vga_rd_valid, vga_drop, vga_drop_count,
        output cpu_rd_req, cpu_rd_addr,
        input  cpu_rd_ack, cpu_rd_valid,
        output cpu_wr_req, cpu_wr_addr, cpu_wr_data,
        input  cpu_wr_ack,
        output ldr_wr_req, ldr_wr_addr, ldr_wr_data,
        input  ldr_wr_ack,
        input  rd_data, mem_rdaddress,
        output mem_q,
        input  mem_wraddress, mem_data, mem_wren
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares the framebuffer RAM: read port between VGA fetch and CPU loads (with a CPU
// starvation override), write port round-robin between CPU stores and the image loader.
module vram_port_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int WDATA_W    = 32,
    parameter int RDATA_W    = 8,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 64
) (
    input  logic               clk,
    input  logic               reset,
    vram_port_arbiter_if.slave bus
);

    localparam int              ST_W       = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [ST_W-1:0] STARVE_LIM = ST_W'(STARVE_MAX);
    localparam logic [15:0]     DROP_SAT   = 16'hFFFF;

    typedef struct packed {
        logic vga;
        logic cpu;
    } rd_tag_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic en);
        logic [15:0] res;
        if (en && (val != DROP_SAT)) begin
            res = val + 16'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

    logic [ST_W-1:0]      starve_q,      starve_d;
    rd_tag_t [RD_LAT-1:0] tag_q,         tag_d;
    logic                 vga_valid_q,   vga_valid_d;
    logic                 cpu_valid_q,   cpu_valid_d;
    logic                 vga_drop_q,    vga_drop_d;
    logic [15:0]          drop_cnt_q,    drop_cnt_d;
    logic [ADDR_W-1:0]    rd_addr_q,     rd_addr_d;
    logic                 wr_pref_ldr_q, wr_pref_ldr_d;
    logic                 wren_q,        wren_d;
    logic [ADDR_W-1:0]    wr_addr_q,     wr_addr_d;
    logic [WDATA_W-1:0]   wr_data_q,     wr_data_d;

    logic override_s;
    logic cpu_rd_gnt_s;
    logic vga_rd_gnt_s;
    logic vga_drop_s;
    logic cpu_wr_gnt_s;
    logic ldr_wr_gnt_s;

    // Combinational grants; nothing is granted while reset is held.
    always_comb begin
        override_s   = (starve_q == STARVE_LIM);
        cpu_rd_gnt_s = 1'b0;
        vga_rd_gnt_s = 1'b0;
        vga_drop_s   = 1'b0;
        cpu_wr_gnt_s = 1'b0;
        ldr_wr_gnt_s = 1'b0;
        if (reset) begin
            cpu_rd_gnt_s = 1'b0;
            vga_rd_gnt_s = 1'b0;
        end else begin
            cpu_rd_gnt_s = bus.cpu_rd_req && (!bus.vga_rd_req || override_s);
            vga_rd_gnt_s = bus.vga_rd_req && !cpu_rd_gnt_s;
            // A VGA strobe that loses to the CPU is not retried by the fetcher.
            vga_drop_s   = bus.vga_rd_req && cpu_rd_gnt_s;
            cpu_wr_gnt_s = bus.cpu_wr_req && (!bus.ldr_wr_req || !wr_pref_ldr_q);
            ldr_wr_gnt_s = bus.ldr_wr_req && (!bus.cpu_wr_req || wr_pref_ldr_q);
        end
    end

    // Read-side next state: starvation counter, read address, tag pipeline, valids.
    always_comb begin
        starve_d = starve_q;
        if (bus.cpu_rd_req && !cpu_rd_gnt_s) begin
            if (starve_q != STARVE_LIM) begin
                starve_d = starve_q + ST_W'(1);
            end else begin
                starve_d = starve_q;
            end
        end else begin
            starve_d = {ST_W{1'b0}};
        end

        rd_addr_d = rd_addr_q;
        if (cpu_rd_gnt_s) begin
            rd_addr_d = bus.cpu_rd_addr;
        end else if (vga_rd_gnt_s) begin
            rd_addr_d = bus.vga_rd_addr;
        end else begin
            rd_addr_d = rd_addr_q;
        end

        // Tag delay matches the RAM latency; the valid flop adds the final edge.
        tag_d        = tag_q;
        tag_d[0].vga = vga_rd_gnt_s;
        tag_d[0].cpu = cpu_rd_gnt_s;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        vga_valid_d = tag_q[RD_LAT-1].vga;
        cpu_valid_d = tag_q[RD_LAT-1].cpu;

        vga_drop_d = vga_drop_s;
        drop_cnt_d = sat_inc16(drop_cnt_q, vga_drop_s);
    end

    // Write-side next state: winner's address/data and round-robin preference.
    always_comb begin
        wren_d        = cpu_wr_gnt_s || ldr_wr_gnt_s;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        wr_pref_ldr_d = wr_pref_ldr_q;
        if (cpu_wr_gnt_s) begin
            wr_addr_d     = bus.cpu_wr_addr;
            wr_data_d     = bus.cpu_wr_data;
            wr_pref_ldr_d = 1'b1;
        end else if (ldr_wr_gnt_s) begin
            wr_addr_d     = bus.ldr_wr_addr;
            wr_data_d     = bus.ldr_wr_data;
            wr_pref_ldr_d = 1'b0;
        end else begin
            wr_addr_d     = wr_addr_q;
            wr_data_d     = wr_data_q;
            wr_pref_ldr_d = wr_pref_ldr_q;
        end
    end

    // State registers; reset drops any reads still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q      <= {ST_W{1'b0}};
            tag_q         <= {RD_LAT{2'b00}};
            vga_valid_q   <= 1'b0;
            cpu_valid_q   <= 1'b0;
            vga_drop_q    <= 1'b0;
            drop_cnt_q    <= 16'h0000;
            rd_addr_q     <= {ADDR_W{1'b0}};
            wr_pref_ldr_q <= 1'b0;
            wren_q        <= 1'b0;
            wr_addr_q     <= {ADDR_W{1'b0}};
            wr_data_q     <= {WDATA_W{1'b0}};
        end else begin
            starve_q      <= starve_d;
            tag_q         <= tag_d;
            vga_valid_q   <= vga_valid_d;
            cpu_valid_q   <= cpu_valid_d;
            vga_drop_q    <= vga_drop_d;
            drop_cnt_q    <= drop_cnt_d;
            rd_addr_q     <= rd_addr_d;
            wr_pref_ldr_q <= wr_pref_ldr_d;
            wren_q        <= wren_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign bus.cpu_rd_ack     = cpu_rd_gnt_s;
    assign bus.cpu_wr_ack     = cpu_wr_gnt_s;
    assign bus.ldr_wr_ack     = ldr_wr_gnt_s;
    assign bus.vga_rd_valid   = vga_valid_q;
    assign bus.cpu_rd_valid   = cpu_valid_q;
    assign bus.vga_drop       = vga_drop_q;
    assign bus.vga_drop_count = drop_cnt_q;
    assign bus.rd_data        = bus.mem_q;
    assign bus.mem_rdaddress  = rd_addr_q;
    assign bus.mem_wraddress  = wr_addr_q;
    assign bus.mem_data       = wr_data_q;
    assign bus.mem_wren       = wren_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: RAM model with fixed read latency and a
// read-return scoreboard; a second instance with STARVE_MAX=0 exercises drop-count saturation.
module tb_vram_port_arbiter;

    localparam int ADDR_W     = 18;
    localparam int WDATA_W    = 32;
    localparam int RDATA_W    = 8;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 64;

    logic clk = 1'b0;
    logic reset;
    logic reset2;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    // Expected read returns in grant order: {is_cpu, data}.
    logic [RDATA_W:0]  exp_rd [$];
    logic [RDATA_W:0]  mon_exp;
    logic [ADDR_W-1:0] rd_pipe [RD_LAT];

    vram_port_arbiter_if #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W)) bus ();
    vram_port_arbiter_if #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W)) bus2 ();

    vram_port_arbiter #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W),
                        .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX))
        dut (.clk(clk), .reset(reset), .bus(bus));

    vram_port_arbiter #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W),
                        .RD_LAT(RD_LAT), .STARVE_MAX(0))
        dut_sat (.clk(clk), .reset(reset2), .bus(bus2));

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_word(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'hB5 ^ {6'b000000, a[17:16]};
    endfunction

    // RAM read model: q follows the presented address after RD_LAT edges.
    always @(posedge clk) begin
        rd_pipe[0] <= bus.mem_rdaddress;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_q  = ram_word(rd_pipe[RD_LAT-1]);
    assign bus2.mem_q = 8'h3C;

    task automatic test_reset();
        reset = 1'b1;
        bus.vga_rd_req = 1'b1; bus.cpu_rd_req = 1'b1;
        bus.cpu_wr_req = 1'b1; bus.ldr_wr_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if ({bus.cpu_rd_ack, bus.cpu_wr_ack, bus.ldr_wr_ack} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_acks: got %b expected 000", {bus.cpu_rd_ack, bus.cpu_wr_ack, bus.ldr_wr_ack});
            end
            @(negedge clk);
        end
        reset = 1'b0;
        bus.vga_rd_req = 1'b0; bus.cpu_rd_req = 1'b0;
        bus.cpu_wr_req = 1'b0; bus.ldr_wr_req = 1'b0;
        mon_en = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_rdaddress !== 18'h00000 || bus.mem_wraddress !== 18'h00000) begin
            n_fail++;
            $display("FAIL reset_addr: got rd=%h wr=%h expected 0", bus.mem_rdaddress, bus.mem_wraddress);
        end
        n_checks++;
        if (bus.mem_data !== 32'h0 || bus.mem_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wr: got data=%h wren=%b expected 0", bus.mem_data, bus.mem_wren);
        end
        n_checks++;
        if (bus.vga_drop !== 1'b0 || bus.vga_drop_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_drop: got drop=%b count=%h expected 0", bus.vga_drop, bus.vga_drop_count);
        end
        for (int c = 0; c < 3 + RD_LAT; c++) begin
            n_checks++;
            if (bus.vga_rd_valid !== 1'b0 || bus.cpu_rd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid: got vga=%b cpu=%b expected 0", bus.vga_rd_valid, bus.cpu_rd_valid);
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_cpu_read();
        bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 18'h00010;
        #1;
        n_checks++;
        if (bus.cpu_rd_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL cpu_read_ack: got %b expected 1", bus.cpu_rd_ack);
        end
        exp_rd.push_back({1'b1, 8'hA5});
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            bus.cpu_rd_req = 1'b0;
            #1;
            if (n == 1) begin
                n_checks++;
                if (bus.mem_rdaddress !== 18'h00010) begin
                    n_fail++;
                    $display("FAIL cpu_read_addr: got %h expected 00010", bus.mem_rdaddress);
                end
            end
            n_checks++;
            if (bus.cpu_rd_valid !== (n == 3) || bus.vga_rd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL cpu_read_timing: step %0d got cpu=%b vga=%b expected cpu=%b vga=0",
                         n, bus.cpu_rd_valid, bus.vga_rd_valid, (n == 3));
            end
        end
    endtask

    task automatic test_starvation();
        int   starve_m = 0;
        bit   pend     = 1'b1;
        bit   drop_prev = 1'b0;
        logic exp_ack;
        for (int c = 1; c <= 100; c++) begin
            bus.vga_rd_req  = 1'b1;
            bus.vga_rd_addr = 18'(c - 1);
            bus.cpu_rd_req  = pend;
            bus.cpu_rd_addr = 18'h20000;
            #1;
            exp_ack = pend && (starve_m == STARVE_MAX);
            n_checks++;
            if (bus.cpu_rd_ack !== exp_ack) begin
                n_fail++;
                $display("FAIL starve_ack: cycle %0d got %b expected %b", c, bus.cpu_rd_ack, exp_ack);
            end
            n_checks++;
            if (bus.vga_drop !== drop_prev) begin
                n_fail++;
                $display("FAIL starve_drop_pulse: cycle %0d got %b expected %b", c, bus.vga_drop, drop_prev);
            end
            if (exp_ack) exp_rd.push_back({1'b1, ram_word(18'h20000)});
            else         exp_rd.push_back({1'b0, ram_word(18'(c - 1))});
            drop_prev = exp_ack;
            starve_m  = (pend && !exp_ack) ? starve_m + 1 : 0;
            if (exp_ack) pend = 1'b0;
            @(negedge clk);
        end
        bus.vga_rd_req = 1'b0; bus.cpu_rd_req = 1'b0;
        #1;
        n_checks++;
        if (bus.vga_drop !== 1'b0 || bus.vga_drop_count !== 16'h0001) begin
            n_fail++;
            $display("FAIL starve_drop_count: got drop=%b count=%h expected 0/0001", bus.vga_drop, bus.vga_drop_count);
        end
        repeat (RD_LAT + 2) @(negedge clk);
        #1;
        n_checks++;
        if (exp_rd.size() != 0) begin
            n_fail++;
            $display("FAIL starve_returns: got %0d outstanding expected 0", exp_rd.size());
        end
    endtask

    task automatic test_write_rr();
        logic [19:0] req_seq = 20'b11_11_11_11_11_11_01_10_11_00;
        logic [19:0] gnt_seq = 20'b10_01_10_01_10_01_01_10_01_00;
        logic [ADDR_W+WDATA_W-1:0] exp_wr [$];
        logic [ADDR_W+WDATA_W-1:0] wexp;
        logic [1:0] r, g;
        int ci = 0, li = 0;
        for (int c = 0; c <= 10; c++) begin
            r = (c < 10) ? req_seq[19-2*c -: 2] : 2'b00;
            g = (c < 10) ? gnt_seq[19-2*c -: 2] : 2'b00;
            bus.cpu_wr_req = r[1]; bus.cpu_wr_addr = 18'h00100 + 18'(ci); bus.cpu_wr_data = 32'hC0DE_0000 + 32'(ci);
            bus.ldr_wr_req = r[0]; bus.ldr_wr_addr = 18'h00200 + 18'(li); bus.ldr_wr_data = 32'hD00D_0000 + 32'(li);
            #1;
            n_checks++;
            if ({bus.cpu_wr_ack, bus.ldr_wr_ack} !== g) begin
                n_fail++;
                $display("FAIL wr_grant: cycle %0d got %b expected %b", c, {bus.cpu_wr_ack, bus.ldr_wr_ack}, g);
            end
            n_checks++;
            if (exp_wr.size() > 0) begin
                wexp = exp_wr.pop_front();
                if (bus.mem_wren !== 1'b1 || {bus.mem_wraddress, bus.mem_data} !== wexp) begin
                    n_fail++;
                    $display("FAIL wr_port: cycle %0d got wren=%b addr=%h data=%h expected wren=1 addr=%h data=%h",
                             c, bus.mem_wren, bus.mem_wraddress, bus.mem_data, wexp[ADDR_W+WDATA_W-1:WDATA_W], wexp[WDATA_W-1:0]);
                end
            end else if (bus.mem_wren !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_idle: cycle %0d got wren=%b expected 0", c, bus.mem_wren);
            end
            if (g[1]) begin
                exp_wr.push_back({bus.cpu_wr_addr, bus.cpu_wr_data}); ci++;
            end else if (g[0]) begin
                exp_wr.push_back({bus.ldr_wr_addr, bus.ldr_wr_data}); li++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 18'h00033;
        #1;
        n_checks++;
        if (bus.cpu_rd_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ack: got %b expected 1", bus.cpu_rd_ack);
        end
        @(negedge clk);
        bus.cpu_rd_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < RD_LAT + 3; n++) begin
            #1;
            n_checks++;
            if (bus.cpu_rd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_lost_read: step %0d got cpu_valid=%b expected 0", n, bus.cpu_rd_valid);
            end
            @(negedge clk);
        end
        bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 18'h00010;
        #1;
        n_checks++;
        if (bus.cpu_rd_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reissue_ack: got %b expected 1", bus.cpu_rd_ack);
        end
        exp_rd.push_back({1'b1, 8'hA5});
        for (int n = 0; n < RD_LAT + 2; n++) begin
            @(negedge clk);
            bus.cpu_rd_req = 1'b0;
            #1;
            if (bus.cpu_rd_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 1 || exp_rd.size() != 0) begin
            n_fail++;
            $display("FAIL mid_reissue_return: got %0d valids, %0d outstanding expected 1 and 0", seen, exp_rd.size());
        end
    endtask

    task automatic test_drop_saturation();
        bus2.vga_rd_req = 1'b1; bus2.vga_rd_addr = 18'h00ABC;
        bus2.cpu_rd_req = 1'b1; bus2.cpu_rd_addr = 18'h00DEF;
        reset2 = 1'b0;
        #1;
        n_checks++;
        if (bus2.cpu_rd_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_override_ack: got %b expected 1", bus2.cpu_rd_ack);
        end
        repeat (65534) @(negedge clk);
        #1;
        n_checks++;
        if (bus2.vga_drop_count !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_count_fffe: got %h expected fffe", bus2.vga_drop_count);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus2.vga_drop_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_count_ffff: got %h expected ffff", bus2.vga_drop_count);
        end
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (bus2.vga_drop_count !== 16'hFFFF || bus2.vga_drop !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_count_stick: got count=%h drop=%b expected ffff/1", bus2.vga_drop_count, bus2.vga_drop);
        end
        n_checks++;
        if (bus2.vga_rd_valid !== 1'b0 || bus2.mem_rdaddress !== 18'h00DEF) begin
            n_fail++;
            $display("FAIL sat_cpu_only: got vga_valid=%b rdaddr=%h expected 0/00def", bus2.vga_rd_valid, bus2.mem_rdaddress);
        end
        bus2.vga_rd_req = 1'b0; bus2.cpu_rd_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        reset2 = 1'b1;
        bus.vga_rd_req = 1'b0; bus.vga_rd_addr = '0;
        bus.cpu_rd_req = 1'b0; bus.cpu_rd_addr = '0;
        bus.cpu_wr_req = 1'b0; bus.cpu_wr_addr = '0; bus.cpu_wr_data = '0;
        bus.ldr_wr_req = 1'b0; bus.ldr_wr_addr = '0; bus.ldr_wr_data = '0;
        bus2.vga_rd_req = 1'b0; bus2.vga_rd_addr = '0;
        bus2.cpu_rd_req = 1'b0; bus2.cpu_rd_addr = '0;
        bus2.cpu_wr_req = 1'b0; bus2.cpu_wr_addr = '0; bus2.cpu_wr_data = '0;
        bus2.ldr_wr_req = 1'b0; bus2.ldr_wr_addr = '0; bus2.ldr_wr_data = '0;

        // Read-return scoreboard: every valid must match the oldest expected grant.
        fork
            forever begin
                @(negedge clk);
                if (mon_en && (bus.vga_rd_valid !== 1'b0 || bus.cpu_rd_valid !== 1'b0)) begin
                    n_checks++;
                    if (exp_rd.size() == 0) begin
                        n_fail++;
                        $display("FAIL rd_unexpected: got vga=%b cpu=%b expected no valid", bus.vga_rd_valid, bus.cpu_rd_valid);
                    end else begin
                        mon_exp = exp_rd.pop_front();
                        if ({bus.cpu_rd_valid, bus.vga_rd_valid} !== {mon_exp[RDATA_W], ~mon_exp[RDATA_W]} ||
                            bus.rd_data !== mon_exp[RDATA_W-1:0]) begin
                            n_fail++;
                            $display("FAIL rd_return: got cpu=%b vga=%b data=%h expected cpu=%b data=%h",
                                     bus.cpu_rd_valid, bus.vga_rd_valid, bus.rd_data, mon_exp[RDATA_W], mon_exp[RDATA_W-1:0]);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_cpu_read();
        test_starvation();
        test_write_rr();
        test_reset_mid();
        test_drop_saturation();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
Shares the dual-port framebuffer RAM between three requesters. The read port (rdaddress/q) serves the VGA scan-out fetcher and PISA core loads; the write port (wraddress/data/wren) serves PISA core stores and the PS/2-driven image loader. It sits between the PISA core, VGA controller and loader on one side and the RAM on the other. It returns read data to the correct requester with a fixed-latency valid pulse. It guarantees forward progress for the core via a starvation limit.

Parameters:
ADDR_W, 18, RAM address width
WDATA_W, 32, write data width
RDATA_W, 8, read data width (q)
RD_LAT, 2, RAM read latency in clk edges from address presented to q valid (1..4)
STARVE_MAX, 64, consecutive denied cycles before a CPU read overrides VGA

Ports:
clk  in  1  system clock; sole clock domain
reset  in  1  synchronous, active-high reset
vga_rd_req  in  1  VGA fetch request, single-cycle strobe
vga_rd_addr  in  ADDR_W  VGA fetch address
vga_rd_valid  out  1  one-cycle pulse; rd_data holds VGA pixel
vga_drop  out  1  one-cycle pulse; a VGA request was discarded
vga_drop_count  out  16  saturating count of dropped VGA requests
cpu_rd_req  in  1  CPU load request; held until acked
cpu_rd_addr  in  ADDR_W  CPU load address
cpu_rd_ack  out  1  combinational; request transfers at the edge where req&&ack
cpu_rd_valid  out  1  one-cycle pulse; rd_data holds CPU load data
cpu_wr_req  in  1  CPU store request; held until acked
cpu_wr_addr  in  ADDR_W  store address
cpu_wr_data  in  WDATA_W  store data
cpu_wr_ack  out  1  combinational write grant
ldr_wr_req  in  1  loader write request; held until acked
ldr_wr_addr  in  ADDR_W  loader address
ldr_wr_data  in  WDATA_W  loader data
ldr_wr_ack  out  1  combinational write grant
rd_data  out  RDATA_W  combinational copy of mem_q
mem_rdaddress  out  ADDR_W  registered RAM read address
mem_q  in  RDATA_W  RAM read data
mem_wraddress  out  ADDR_W  registered RAM write address
mem_data  out  WDATA_W  registered RAM write data
mem_wren  out  1  registered RAM write enable

Behaviour:
- Reset:
  - All registered outputs clear to 0: mem_rdaddress, mem_wraddress, mem_data, mem_wren, vga_drop, vga_drop_count.
  - Valid pipeline clears, so no *_valid pulse is emitted for requests transferred before reset.
  - starve_cnt clears to 0.
  - Write round-robin pointer resets to favour the CPU.
- Read arbitration (per cycle, combinational grant):
  - VGA wins over CPU unless starve_cnt == STARVE_MAX.
  - In that override cycle the CPU is acked. If vga_rd_req is also high, the VGA request is discarded: vga_drop pulses next cycle and vga_drop_count increments, saturating at 0xFFFF.
  - cpu_rd_ack = cpu_rd_req && (!vga_rd_req || starve_cnt == STARVE_MAX).
- starve_cnt:
  - Increments each cycle cpu_rd_req && !cpu_rd_ack.
  - Clears on an ack or when cpu_rd_req is low.
  - Never exceeds STARVE_MAX.
- Read transfer at edge k:
  - mem_rdaddress takes the winner's address.
  - A 2-bit tag {vga,cpu} enters a RD_LAT-deep shift register.
  - The matching *_valid is high for exactly the one cycle following edge k+RD_LAT; rd_data = mem_q in that cycle.
  - With no grant, mem_rdaddress holds and a null tag is shifted.
- Read throughput: one read per cycle, back-to-back, mixed requesters. Valid pulses appear in grant order.
- Write arbitration:
  - A single requester is acked immediately.
  - When both request, the grant alternates, starting with CPU after reset. The pointer flips to the other requester after each contended grant.
  - An uncontended grant sets the pointer to the other requester.
- Write transfer at edge k:
  - mem_wren = 1, with mem_wraddress/mem_data = winner's values, in the cycle after edge k.
  - mem_wren = 0 in any cycle with no grant.
  - Maximum one write per cycle.
- Read and write to the same address in the same cycle: no forwarding; the RAM's read-during-write (old data) result is returned.
- Reset mid-operation: any acked-but-unreturned reads are lost. Requesters must reissue.

Test Plan:
- Reset asserted 3 cycles with all reqs high -> all acks 0 during reset; after release, all registered outputs 0 and no *_valid for 3+RD_LAT cycles.
- CPU read 0x00010 alone, mem_q = 0xA5 model (RD_LAT=2) -> cpu_rd_ack in request cycle; cpu_rd_valid one cycle after edge k+2 with rd_data=0xA5; vga_rd_valid stays 0.
- VGA strobes every cycle, addresses 0..99, and CPU reads 0x20000 continuously -> CPU acked on cycle 65 (STARVE_MAX=64); vga_drop pulses once; vga_drop_count=1; all 99 other VGA valids return in order.
- Both writers request continuously for 6 cycles with distinct addr/data -> grants CPU, LDR, CPU, LDR, CPU, LDR; mem_wren high 6 consecutive cycles with matching addr/data.
- Drop-count saturation: preload via 65536+ forced overrides -> count sticks at 0xFFFF.
- Reset pulsed one cycle after a CPU read ack -> no cpu_rd_valid produced; next read returns correctly.
